// File: rtl/obstacle_pixel_renderer.sv
// Obstacle pixel renderer: shadow/active slot geometry, 2-stage hit pipeline,
// per-frame bird/obstacle collision reporting.
//
// Ports:
//   clk, reset_n            clock, async active-low reset
//   obs_valid/obs_ready     geometry write handshake
//   obs_idx, obs_en         target slot, slot enable
//   obs_left/right          column span [left, right), left > right wraps
//   obs_ytop/ybot           gap rows [ytop, ybot), pipes outside
//   frame_start             vertical-blank pulse, latches shadow into active
//   pix_valid/x/y           scan pixel
//   bird_pixel              bird covers the scan pixel
//   obs_pixel(_valid)       obstacle coverage, 2 cycles after the pixel
//   collision(_count)       overlap summary of the previous frame
module obstacle_pixel_renderer #(
    parameter int N_OBS         = 3,
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    localparam int IDXW = (N_OBS > 1) ? $clog2(N_OBS) : 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            obs_valid,
    output logic            obs_ready,
    input  logic [IDXW-1:0] obs_idx,
    input  logic            obs_en,
    input  logic [9:0]      obs_left,
    input  logic [9:0]      obs_right,
    input  logic [8:0]      obs_ytop,
    input  logic [8:0]      obs_ybot,
    input  logic            frame_start,
    input  logic            pix_valid,
    input  logic [9:0]      pix_x,
    input  logic [8:0]      pix_y,
    input  logic            bird_pixel,
    output logic            obs_pixel,
    output logic            obs_pixel_valid,
    output logic            collision,
    output logic [7:0]      collision_count
);

    typedef struct packed {
        logic       en;
        logic [9:0] left;
        logic [9:0] right;
        logic [8:0] ytop;
        logic [8:0] ybot;
    } slot_t;

    localparam logic [0:0]    ST_LOAD = 1'b0;
    localparam logic [0:0]    ST_COPY = 1'b1;
    localparam logic [IDXW:0] NOBS_W  = (IDXW + 1)'(N_OBS);
    localparam logic [10:0]   XLIM    = 11'(SCREEN_WIDTH);
    localparam logic [9:0]    YLIM    = 10'(SCREEN_HEIGHT);

    logic [0:0]       state_q, state_d;
    slot_t            shadow_q [N_OBS];
    slot_t            shadow_d [N_OBS];
    slot_t            active_q [N_OBS];
    slot_t            active_d [N_OBS];
    logic [N_OBS-1:0] hit_d, hit_s1_q;
    logic             valid_s1_q, bird_s1_q, bird_s2_q;
    logic             obs_pixel_q, obs_pixel_valid_q;
    logic             collision_q, collision_d;
    logic [7:0]       acc_q, acc_d, count_q, count_d;
    logic [8:0]       sum;
    logic [7:0]       total;
    logic             accept, copy, inc, on_screen;

    function automatic logic slot_hit(slot_t s, logic [9:0] x, logic [8:0] y);
        logic in_x;
        logic in_y;
        // left > right means the right edge wrapped past 1023
        if (s.left <= s.right) in_x = (x >= s.left) && (x < s.right);
        else                   in_x = (x >= s.left);
        // an empty gap (ytop >= ybot) makes this true for every row
        in_y = (y < s.ytop) || (y >= s.ybot);
        return s.en && in_x && in_y;
    endfunction

    assign obs_ready = (state_q == ST_LOAD);
    assign accept    = obs_valid && obs_ready && ({1'b0, obs_idx} < NOBS_W);
    // copy on the frame_start edge itself, so a write in that same
    // cycle lands in shadow only and shows up one frame later
    assign copy      = frame_start && (state_q == ST_LOAD);
    assign on_screen = ({1'b0, pix_x} < XLIM) && ({1'b0, pix_y} < YLIM);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_LOAD: if (frame_start) state_d = ST_COPY;
            ST_COPY: state_d = ST_LOAD;
            default: state_d = ST_LOAD;
        endcase
    end

    always_comb begin
        for (int k = 0; k < N_OBS; k++) begin
            shadow_d[k] = shadow_q[k];
            active_d[k] = copy ? shadow_q[k] : active_q[k];
            if (accept && (obs_idx == IDXW'(k))) begin
                shadow_d[k] = '{en: obs_en, left: obs_left,
                                right: obs_right, ytop: obs_ytop,
                                ybot: obs_ybot};
            end
            hit_d[k] = on_screen && slot_hit(active_q[k], pix_x, pix_y);
        end
    end

    assign inc = obs_pixel_q && bird_s2_q;

    always_comb begin
        sum         = {1'b0, acc_q} + {8'd0, inc};
        total       = sum[8] ? 8'hFF : sum[7:0];
        acc_d       = frame_start ? 8'd0 : total;
        count_d     = count_q;
        collision_d = collision_q;
        if (frame_start) begin
            count_d     = total;
            collision_d = (total != 8'd0);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_LOAD;
            for (int k = 0; k < N_OBS; k++) begin
                shadow_q[k] <= '0;
                active_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            for (int k = 0; k < N_OBS; k++) begin
                shadow_q[k] <= shadow_d[k];
                active_q[k] <= active_d[k];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_s1_q          <= '0;
            valid_s1_q        <= 1'b0;
            bird_s1_q         <= 1'b0;
            bird_s2_q         <= 1'b0;
            obs_pixel_q       <= 1'b0;
            obs_pixel_valid_q <= 1'b0;
        end else begin
            hit_s1_q          <= hit_d;
            valid_s1_q        <= pix_valid;
            bird_s1_q         <= bird_pixel;
            bird_s2_q         <= bird_s1_q && valid_s1_q;
            obs_pixel_q       <= (|hit_s1_q) && valid_s1_q;
            obs_pixel_valid_q <= valid_s1_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q       <= 8'd0;
            count_q     <= 8'd0;
            collision_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            count_q     <= count_d;
            collision_q <= collision_d;
        end
    end

    assign obs_pixel       = obs_pixel_q;
    assign obs_pixel_valid = obs_pixel_valid_q;
    assign collision       = collision_q;
    assign collision_count = count_q;

endmodule

// File: tb/tb_obstacle_pixel_renderer.sv
// Self-checking bench for obstacle_pixel_renderer: directed literal probes
// plus randomized traffic compared every cycle against a behavioural model.
module tb_obstacle_pixel_renderer;

    localparam int N_OBS = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       obs_valid = 1'b0;
    logic       obs_ready;
    logic [1:0] obs_idx = '0;
    logic       obs_en = 1'b0;
    logic [9:0] obs_left = '0;
    logic [9:0] obs_right = '0;
    logic [8:0] obs_ytop = '0;
    logic [8:0] obs_ybot = '0;
    logic       frame_start = 1'b0;
    logic       pix_valid = 1'b0;
    logic [9:0] pix_x = '0;
    logic [8:0] pix_y = '0;
    logic       bird_pixel = 1'b0;
    logic       obs_pixel;
    logic       obs_pixel_valid;
    logic       collision;
    logic [7:0] collision_count;

    int total = 0;
    int bad = 0;

    obstacle_pixel_renderer #(
        .N_OBS(N_OBS), .SCREEN_WIDTH(640), .SCREEN_HEIGHT(480)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .obs_valid(obs_valid), .obs_ready(obs_ready),
        .obs_idx(obs_idx), .obs_en(obs_en),
        .obs_left(obs_left), .obs_right(obs_right),
        .obs_ytop(obs_ytop), .obs_ybot(obs_ybot),
        .frame_start(frame_start),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .bird_pixel(bird_pixel),
        .obs_pixel(obs_pixel), .obs_pixel_valid(obs_pixel_valid),
        .collision(collision), .collision_count(collision_count)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t",
                         nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit en;
        int l;
        int r;
        int yt;
        int yb;
    } mslot_t;

    mslot_t m_sh [N_OBS];
    mslot_t m_act [N_OBS];
    bit m_blk;
    bit s1v, s1h, s1b;
    bit e_px, e_pv, e_b, e_coll;
    int acc, e_cnt;

    function automatic bit covers(mslot_t s, int x, int y);
        bit ix;
        bit iy;
        if (!s.en) return 1'b0;
        if (s.l <= s.r) ix = (x >= s.l) && (x < s.r);
        else            ix = (x >= s.l);
        iy = (y < s.yt) || (y >= s.yb);
        return ix && iy;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        int  inc;
        int  tot;
        bit  h;
        bit  wr_ok;
        if (!reset_n) begin
            for (int k = 0; k < N_OBS; k++) begin
                m_sh[k]  = '{0, 0, 0, 0, 0};
                m_act[k] = '{0, 0, 0, 0, 0};
            end
            m_blk = 0;
            s1v = 0; s1h = 0; s1b = 0;
            e_px = 0; e_pv = 0; e_b = 0; e_coll = 0;
            acc = 0; e_cnt = 0;
        end else begin
            inc = (e_px && e_b) ? 1 : 0;
            tot = acc + inc;
            if (tot > 255) tot = 255;
            if (frame_start) begin
                e_coll = (tot != 0);
                e_cnt  = tot;
                acc    = 0;
            end else begin
                acc = tot;
            end
            e_px = s1h && s1v;
            e_pv = s1v;
            e_b  = s1b && s1v;
            h = 0;
            for (int k = 0; k < N_OBS; k++)
                if (covers(m_act[k], int'(pix_x), int'(pix_y))) h = 1;
            s1v = pix_valid;
            s1h = h;
            s1b = bird_pixel;
            wr_ok = obs_valid && !m_blk && (int'(obs_idx) < N_OBS);
            if (frame_start && !m_blk) begin
                for (int k = 0; k < N_OBS; k++) m_act[k] = m_sh[k];
                m_blk = 1;
            end else begin
                m_blk = 0;
            end
            if (wr_ok)
                m_sh[obs_idx] = '{obs_en, int'(obs_left), int'(obs_right),
                                  int'(obs_ytop), int'(obs_ybot)};
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            chk("m_obs_pixel", int'(obs_pixel), int'(e_px));
            chk("m_obs_pixel_valid", int'(obs_pixel_valid), int'(e_pv));
            chk("m_collision", int'(collision), int'(e_coll));
            chk("m_collision_count", int'(collision_count), e_cnt);
            chk("m_obs_ready", int'(obs_ready), int'(!m_blk));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        obs_valid = 0;
        frame_start = 0;
        pix_valid = 0;
        bird_pixel = 0;
    endtask

    task automatic fstart();
        frame_start = 1;
        tick();
        frame_start = 0;
        tick();
    endtask

    task automatic set_geo(int idx, bit en, int l, int r, int yt, int yb);
        obs_idx   = idx[1:0];
        obs_en    = en;
        obs_left  = l[9:0];
        obs_right = r[9:0];
        obs_ytop  = yt[8:0];
        obs_ybot  = yb[8:0];
    endtask

    task automatic wr(int idx, bit en, int l, int r, int yt, int yb);
        set_geo(idx, en, l, r, yt, yb);
        obs_valid = 1;
        tick();
        obs_valid = 0;
    endtask

    task automatic probe(int x, int y, bit exp, string nm);
        pix_valid = 1;
        pix_x = x[9:0];
        pix_y = y[8:0];
        tick();
        pix_valid = 0;
        tick();
        chk(nm, int'(obs_pixel), int'(exp));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int ones;
        int vcnt;
        int pres;

        repeat (3) tick();
        chk("reset_ready", int'(obs_ready), 1);
        chk("reset_obs_pixel_valid", int'(obs_pixel_valid), 0);
        reset_n = 1;
        tick();

        // 1: empty frame scan
        ones = 0; vcnt = 0; pres = 0;
        for (int y = 0; y < 480; y += 16) begin
            for (int x = 0; x < 640; x += 8) begin
                pix_valid = ((x / 8) % 5) != 4;
                pix_x = x[9:0];
                pix_y = y[8:0];
                if (pix_valid) pres++;
                tick();
                ones += int'(obs_pixel);
                vcnt += int'(obs_pixel_valid);
            end
        end
        pix_valid = 0;
        repeat (2) begin
            tick();
            ones += int'(obs_pixel);
            vcnt += int'(obs_pixel_valid);
        end
        chk("empty_no_hits", ones, 0);
        chk("empty_valid_count", vcnt, pres);
        fstart();
        chk("empty_collision", int'(collision), 0);

        // 2: basic slot geometry
        wr(0, 1, 100, 160, 150, 270);
        probe(120, 10, 0, "shadow_not_drawn");
        fstart();
        probe(99, 10, 0, "x99");
        probe(100, 10, 1, "x100");
        probe(159, 10, 1, "x159");
        probe(160, 10, 0, "x160");
        probe(120, 149, 1, "y149");
        probe(120, 150, 0, "y150");
        probe(120, 269, 0, "y269");
        probe(120, 270, 1, "y270");
        probe(120, 479, 1, "y479");

        // 3: write coincident with frame_start is deferred one frame
        set_geo(1, 1, 300, 340, 100, 380);
        obs_valid = 1;
        frame_start = 1;
        tick();
        chk("ready_in_copy", int'(obs_ready), 0);
        obs_valid = 0;
        frame_start = 0;
        tick();
        chk("ready_after_copy", int'(obs_ready), 1);
        probe(310, 10, 0, "deferred_not_yet");
        fstart();
        probe(310, 10, 1, "deferred_now");
        probe(310, 200, 0, "deferred_gap");

        // 4: wrapped columns and an empty gap
        wr(2, 1, 620, 4, 100, 300);
        fstart();
        probe(639, 0, 1, "wrap_639");
        probe(619, 0, 0, "wrap_619");
        probe(0, 0, 0, "wrap_0");
        wr(2, 1, 400, 420, 200, 200);
        fstart();
        probe(410, 199, 1, "solid_199");
        probe(410, 200, 1, "solid_200");
        probe(410, 300, 1, "solid_300");
        probe(420, 300, 0, "solid_right_excl");

        // 5: collision accounting
        fstart();
        for (int i = 0; i < 12; i++) begin
            pix_valid = 1;
            bird_pixel = 1;
            pix_x = 10'd120;
            pix_y = 9'(10 + i);
            tick();
        end
        idle_in();
        repeat (2) tick();
        frame_start = 1;
        tick();
        frame_start = 0;
        chk("coll12_flag", int'(collision), 1);
        chk("coll12_count", int'(collision_count), 12);
        tick();
        fstart();
        chk("clean_flag", int'(collision), 0);
        chk("clean_count", int'(collision_count), 0);
        for (int i = 0; i < 300; i++) begin
            pix_valid = 1;
            bird_pixel = 1;
            pix_x = 10'(100 + i % 60);
            pix_y = 9'(i / 60);
            tick();
        end
        idle_in();
        repeat (2) tick();
        frame_start = 1;
        tick();
        frame_start = 0;
        chk("coll300_count", int'(collision_count), 255);
        chk("coll300_flag", int'(collision), 1);
        tick();

        // randomized traffic
        for (int f = 0; f < 24; f++) begin
            for (int c = 0; c < 500; c++) begin
                pix_valid = ($urandom_range(0, 9) < 8);
                pix_x = 10'($urandom_range(0, 639));
                pix_y = 9'($urandom_range(0, 479));
                bird_pixel = ($urandom_range(0, 9) < 3);
                obs_valid = ($urandom_range(0, 9) == 0);
                set_geo($urandom_range(0, 3), ($urandom_range(0, 4) != 0),
                        $urandom_range(0, 700), $urandom_range(0, 1023),
                        $urandom_range(0, 511), $urandom_range(0, 511));
                frame_start = ($urandom_range(0, 199) == 0);
                tick();
            end
            idle_in();
            frame_start = 1;
            tick();
            frame_start = (f % 3 == 0);
            tick();
            frame_start = 0;
            tick();
        end
        idle_in();

        // 6: reset mid-scan
        wr(0, 1, 100, 160, 150, 270);
        fstart();
        for (int i = 0; i < 300; i++) begin
            pix_valid = 1;
            bird_pixel = 1;
            pix_x = 10'(100 + i % 60);
            pix_y = 9'(i / 60);
            tick();
        end
        frame_start = 1;
        tick();
        frame_start = 0;
        for (int i = 0; i < 4; i++) begin
            pix_valid = 1;
            bird_pixel = 0;
            pix_x = 10'd120;
            pix_y = 9'(i);
            tick();
        end
        chk("pre_reset_pixel", int'(obs_pixel), 1);
        chk("pre_reset_coll", int'(collision), 1);
        #2;
        reset_n = 0;
        #1;
        chk("async_obs_pixel", int'(obs_pixel), 0);
        chk("async_obs_pixel_valid", int'(obs_pixel_valid), 0);
        chk("async_collision", int'(collision), 0);
        chk("async_count", int'(collision_count), 0);
        chk("async_ready", int'(obs_ready), 1);
        idle_in();
        tick();
        reset_n = 1;
        tick();
        fstart();
        probe(120, 10, 0, "post_reset_empty");
        probe(639, 0, 0, "post_reset_empty2");
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
